router_sync_n: RTL and testbench

- Parametrised successor of the 1x3 router synchroniser; generalises it to NUM_CH output FIFOs with a configurable stall timeout.
- Latches the destination address on the header byte and steers write enables to the selected FIFO; muxes back that FIFO's full flag.
- Generates per-channel valid-out and per-channel soft-reset when a valid FIFO is not read for TIMEOUT cycles.
- New behaviour: out-of-range address detection (addr_err) with write suppression, and a combined soft-reset summary.
- Sits between the router FSM/register block and the NUM_CH output FIFOs.

---
 rtl/router_pkg.sv | 12 +
 rtl/router_sync_timer.sv | 37 +++
 rtl/router_sync_n.sv | 72 +++++++
 tb/tb_router_sync_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared defaults and width helpers for the router synchroniser slice.
package router_pkg;

  localparam int unsigned DefNumCh   = 3;
  localparam int unsigned DefTimeout = 30;

  // Returns $clog2(n), but never less than 1 so a single-bit field always exists
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall timer: emits a one-cycle soft_reset when a valid FIFO
// has gone unread for TIMEOUT consecutive edges.
module router_sync_timer #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             soft_reset_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else if (!vld || rd) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b1;
    end else begin
      cnt_q        <= cnt_q + 1'b1;
      soft_reset_q <= 1'b0;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// NUM_CH-way router synchroniser: latches the header address, steers FIFO
// write enables, returns the addressed full flag and drives stall soft-resets.
module router_sync_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned ADDR_W  = clog2_min1(NUM_CH),
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned CNT_W   = clog2_min1(TIMEOUT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              soft_reset_any,
  output logic              addr_err
);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else if (detect_add) begin
      addr_q     <= data_in;
      addr_err_q <= (32'(data_in) >= NUM_CH);
    end
  end

  // addr_q only indexes the vectors while it is known to be in range
  always_comb begin
    write_enb = '0;
    if (!reset && write_enb_reg && !addr_err_q) begin
      write_enb[addr_q] = 1'b1;
    end
  end

  always_comb begin
    fifo_full = 1'b0;
    if (!reset && !addr_err_q) begin
      fifo_full = full[addr_q];
    end
  end

  assign vld_out        = ~empty;
  assign addr_err       = addr_err_q;
  assign soft_reset_any = |soft_reset;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .soft_reset (soft_reset[i])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n (3ch/30 and 4ch/5 builds).
module tb_router_sync_n;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // Default build: NUM_CH=3, TIMEOUT=30
  logic       reset, detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic [2:0] read_enb, empty, full;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       fifo_full, soft_reset_any, addr_err;

  // Small build: NUM_CH=4, TIMEOUT=5
  logic       reset4, detect_add4, write_enb_reg4;
  logic [1:0] data_in4;
  logic [3:0] read_enb4, empty4, full4;
  logic [3:0] write_enb4, vld_out4, soft_reset4;
  logic       fifo_full4, soft_reset_any4, addr_err4;

  int n_checks = 0;
  int n_fail   = 0;

  router_sync_n u_dut (
    .clock          (clock),
    .reset          (reset),
    .detect_add     (detect_add),
    .data_in        (data_in),
    .write_enb_reg  (write_enb_reg),
    .read_enb       (read_enb),
    .empty          (empty),
    .full           (full),
    .write_enb      (write_enb),
    .fifo_full      (fifo_full),
    .vld_out        (vld_out),
    .soft_reset     (soft_reset),
    .soft_reset_any (soft_reset_any),
    .addr_err       (addr_err)
  );

  router_sync_n #(
    .NUM_CH  (4),
    .TIMEOUT (5)
  ) u_dut4 (
    .clock          (clock),
    .reset          (reset4),
    .detect_add     (detect_add4),
    .data_in        (data_in4),
    .write_enb_reg  (write_enb_reg4),
    .read_enb       (read_enb4),
    .empty          (empty4),
    .full           (full4),
    .write_enb      (write_enb4),
    .fifo_full      (fifo_full4),
    .vld_out        (vld_out4),
    .soft_reset     (soft_reset4),
    .soft_reset_any (soft_reset_any4),
    .addr_err       (addr_err4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b1;
    read_enb = 3'b000; empty = 3'b000; full = 3'b111;
    reset4 = 1'b1; detect_add4 = 1'b0; data_in4 = 2'd0; write_enb_reg4 = 1'b0;
    read_enb4 = 4'b0000; empty4 = 4'b1111; full4 = 4'b0000;
    repeat (3) tick();
    n_checks++;
    if (soft_reset !== 3'b000 || addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: soft_reset=%b addr_err=%b, required 000 0", soft_reset, addr_err);
    end
    n_checks++;
    if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb: write_enb=%b fifo_full=%b, required 000 0", write_enb, fifo_full);
    end
    n_checks++;
    if (vld_out !== 3'b111 || soft_reset_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vld: vld_out=%b any=%b, required 111 0", vld_out, soft_reset_any);
    end
    write_enb_reg = 1'b0; full = 3'b000; empty = 3'b111;
    reset = 1'b0; reset4 = 1'b0;
    tick();
  endtask

  task automatic test_steer();
    detect_add = 1'b1; data_in = 2'd2;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
    #1;
    n_checks++;
    if (write_enb !== 3'b100 || fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL steer_addr2: write_enb=%b fifo_full=%b, required 100 1", write_enb, fifo_full);
    end
    detect_add = 1'b1; data_in = 2'd0;
    #1;
    n_checks++;
    if (write_enb !== 3'b100) begin
      n_fail++;
      $display("FAIL steer_same_cycle: write_enb=%b, required 100", write_enb);
    end
    tick();
    detect_add = 1'b0;
    #1;
    n_checks++;
    if (write_enb !== 3'b001 || fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_addr0: write_enb=%b fifo_full=%b, required 001 0", write_enb, fifo_full);
    end
    write_enb_reg = 1'b0;
    #1;
    n_checks++;
    if (write_enb !== 3'b000) begin
      n_fail++;
      $display("FAIL steer_idle: write_enb=%b, required 000", write_enb);
    end
    full = 3'b000;
  endtask

  // Stall channel 1 and expect pulses after edge 30 and edge 60
  task automatic test_timeout();
    empty = 3'b101;
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k < 30; k++) begin
        tick();
        n_checks++;
        if (soft_reset !== 3'b000) begin
          n_fail++;
          $display("FAIL timeout_early: pass %0d edge %0d soft_reset=%b, required 000",
                   p, k, soft_reset);
        end
      end
      tick();
      n_checks++;
      if (soft_reset !== 3'b010 || soft_reset_any !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_pulse: pass %0d soft_reset=%b any=%b, required 010 1",
                 p, soft_reset, soft_reset_any);
      end
    end
    tick();
    n_checks++;
    if (soft_reset !== 3'b000 || soft_reset_any !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_one_cycle: soft_reset=%b any=%b, required 000 0",
               soft_reset, soft_reset_any);
    end
    empty = 3'b111;
    tick();
  endtask

  task automatic test_cancel();
    empty = 3'b101;
    repeat (29) tick();
    read_enb = 3'b010;
    tick();
    read_enb = 3'b000;
    n_checks++;
    if (soft_reset !== 3'b000) begin
      n_fail++;
      $display("FAIL cancel_read: soft_reset=%b, required 000", soft_reset);
    end
    // Counter must have restarted: pulse lands exactly 30 edges later
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (soft_reset !== ((k == 30) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL cancel_restart: edge %0d soft_reset=%b, required %b",
                 k, soft_reset, (k == 30) ? 3'b010 : 3'b000);
      end
    end
    repeat (15) tick();
    empty = 3'b111;
    tick();
    empty = 3'b101;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (soft_reset !== ((k == 30) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL cancel_empty: edge %0d soft_reset=%b, required %b",
                 k, soft_reset, (k == 30) ? 3'b010 : 3'b000);
      end
    end
    empty = 3'b111;
    tick();
  endtask

  task automatic test_addr_err();
    full = 3'b111;
    detect_add = 1'b1; data_in = 2'd3;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (addr_err !== 1'b1 || write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_err_set: addr_err=%b write_enb=%b fifo_full=%b, required 1 000 0",
               addr_err, write_enb, fifo_full);
    end
    tick();
    n_checks++;
    if (addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_err_hold: addr_err=%b, required 1", addr_err);
    end
    detect_add = 1'b1; data_in = 2'd1;
    tick();
    detect_add = 1'b0;
    #1;
    n_checks++;
    if (addr_err !== 1'b0 || write_enb !== 3'b010 || fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_err_clear: addr_err=%b write_enb=%b fifo_full=%b, required 0 010 1",
               addr_err, write_enb, fifo_full);
    end
    write_enb_reg = 1'b0; full = 3'b000;
  endtask

  task automatic test_multi_channel();
    empty4 = 4'b0110;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (soft_reset4 !== ((k == 5) ? 4'b1001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL multi_pulse: edge %0d soft_reset=%b, required %b",
                 k, soft_reset4, (k == 5) ? 4'b1001 : 4'b0000);
      end
    end
    n_checks++;
    if (soft_reset_any4 !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_any: soft_reset_any=%b, required 1", soft_reset_any4);
    end
    repeat (3) tick();  // counters now at 3
    reset4 = 1'b1;
    tick();
    reset4 = 1'b0;
    n_checks++;
    if (soft_reset4 !== 4'b0000 || addr_err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_reset: soft_reset=%b addr_err=%b, required 0000 0",
               soft_reset4, addr_err4);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (soft_reset4 !== ((k == 5) ? 4'b1001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL multi_restart: edge %0d soft_reset=%b, required %b",
                 k, soft_reset4, (k == 5) ? 4'b1001 : 4'b0000);
      end
    end
    empty4 = 4'b1111;
    tick();
  endtask

  initial begin
    test_reset();
    test_steer();
    test_timeout();
    test_cancel();
    test_addr_err();
    test_multi_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
